commit_trace_fifo: RTL and testbench

//  Downstream consumer of the single-cycle CPU's registered commit_* bundle. Captures one

---
 rtl/commit_trace_fifo.sv | 155 +++++++++++++++
 tb/tb_commit_trace_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_fifo.sv
// ---------------------------------------------------------------------------
// commit_trace_fifo
//
// Purpose:
//   Sits behind the single-cycle CPU's registered commit bundle. Each committed
//   instruction becomes one 168-bit trace record in a small FIFO, which is
//   handed to the debug/difftest host over a valid/ready port. It also asks the
//   CPU to stall when the FIFO is nearly full, follows the HALT sequence
//   (RUN -> DRAIN -> HALTED), flags dropped records and counts accepted ones.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   commit*         commit record from the CPU (valid + pc/inst/halt/reg/dmem)
//   out_valid       out_rec holds the oldest stored record
//   out_ready       host takes out_rec this cycle
//   out_rec         {halt,dmem_wd,dmem_wa,dmem_we,reg_wd,reg_wa,reg_we,inst,pc}
//   stall_req       request to drop global_en (near full or not running)
//   halted          HALT committed and FIFO fully drained (sticky)
//   overflow        a record was dropped because the FIFO was full (sticky)
//   commit_cnt      number of accepted records, wraps at 2^32
//   occupancy       entries currently stored
// ---------------------------------------------------------------------------
module commit_trace_fifo #(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     commit,
   input  logic [31:0]              commit_pc,
   input  logic [31:0]              commit_inst,
   input  logic                     commit_halt,
   input  logic                     commit_reg_we,
   input  logic [4:0]               commit_reg_wa,
   input  logic [31:0]              commit_reg_wd,
   input  logic                     commit_dmem_we,
   input  logic [31:0]              commit_dmem_wa,
   input  logic [31:0]              commit_dmem_wd,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [167:0]             out_rec,
   output logic                     stall_req,
   output logic                     halted,
   output logic                     overflow,
   output logic [31:0]              commit_cnt,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int RW = 168;
   localparam logic [AW:0] FULL_CNT  = (AW+1)'(DEPTH);
   localparam logic [AW:0] STALL_CNT = (AW+1)'(DEPTH - 2);

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t         state;
   logic [RW-1:0]  mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [AW:0]    occ_next;
   logic [RW-1:0]  rec_in;
   logic           full;
   logic           running;
   logic           push;
   logic           pop;
   logic           drop;

   // Pack the commit bundle into one record, pc in the low word.
   assign rec_in = {commit_halt, commit_dmem_wd, commit_dmem_wa, commit_dmem_we,
                    commit_reg_wd, commit_reg_wa, commit_reg_we, commit_inst, commit_pc};

   assign running   = (state == RUN);
   assign full      = (occupancy == FULL_CNT);
   assign out_valid = (occupancy != '0);
   assign pop       = out_valid & out_ready;

   // A full FIFO can still accept a record when the head leaves in the same
   // cycle; only a full FIFO with no pop loses the incoming record.
   assign push = commit & running & (~full | pop);
   assign drop = commit & running & full & ~pop;

   // The DEPTH-2 threshold leaves room for the commit already in flight
   // while global_en is being dropped.
   assign stall_req = (occupancy >= STALL_CNT) | ~running;
   assign halted    = (state == HALTED);

   // Head of the FIFO is read straight from storage; it only changes when the
   // read pointer moves, so it stays stable while the host back-pressures.
   assign out_rec = out_valid ? mem[rd_ptr] : '0;

   // Occupancy after this edge; also used to leave DRAIN in the same cycle
   // the last record is taken.
   always_comb begin
      occ_next = occupancy;
      case ({push, pop})
         2'b10:   occ_next = occupancy + 1'b1;
         2'b01:   occ_next = occupancy - 1'b1;
         default: occ_next = occupancy;
      endcase
   end

   // Record storage; stale contents are harmless because out_rec is masked
   // whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= rec_in;
      end
   end

   // Pointers, counters, sticky flags and the halt-sequence FSM.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occupancy  <= '0;
         commit_cnt <= '0;
         overflow   <= 1'b0;
         state      <= RUN;
      end else begin
         occupancy <= occ_next;
         if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            commit_cnt <= commit_cnt + 32'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         case (state)
            RUN: begin
               if (push && commit_halt) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (occ_next == '0) begin
                  state <= HALTED;
               end
            end
            HALTED: begin
               state <= HALTED;
            end
            default: begin
               state <= RUN;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_commit_trace_fifo.sv
// ---------------------------------------------------------------------------
// tb_commit_trace_fifo
//
// Purpose:
//   Directed self-checking bench for commit_trace_fifo (DEPTH=16). Records are
//   derived from their pc so every expected value can be rebuilt here.
// ---------------------------------------------------------------------------
module tb_commit_trace_fifo;

   logic          clk;
   logic          rst;
   logic          commit;
   logic [31:0]   commit_pc;
   logic [31:0]   commit_inst;
   logic          commit_halt;
   logic          commit_reg_we;
   logic [4:0]    commit_reg_wa;
   logic [31:0]   commit_reg_wd;
   logic          commit_dmem_we;
   logic [31:0]   commit_dmem_wa;
   logic [31:0]   commit_dmem_wd;
   logic          out_valid;
   logic          out_ready;
   logic [167:0]  out_rec;
   logic          stall_req;
   logic          halted;
   logic          overflow;
   logic [31:0]   commit_cnt;
   logic [4:0]    occupancy;

   int numChecks = 0;
   int numPass   = 0;

   commit_trace_fifo #(.DEPTH(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .commit         (commit),
      .commit_pc      (commit_pc),
      .commit_inst    (commit_inst),
      .commit_halt    (commit_halt),
      .commit_reg_we  (commit_reg_we),
      .commit_reg_wa  (commit_reg_wa),
      .commit_reg_wd  (commit_reg_wd),
      .commit_dmem_we (commit_dmem_we),
      .commit_dmem_wa (commit_dmem_wa),
      .commit_dmem_wd (commit_dmem_wd),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_rec        (out_rec),
      .stall_req      (stall_req),
      .halted         (halted),
      .overflow       (overflow),
      .commit_cnt     (commit_cnt),
      .occupancy      (occupancy)
   );

   // 10-unit clock period
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction word used for a given pc; HALT always carries 0x8000_0000.
   function automatic logic [31:0] instFor(input logic [31:0] pc, input logic h);
      return h ? 32'h8000_0000 : {pc[15:0], 16'h0013};
   endfunction

   // Expected record for a commit at pc, in the documented field order.
   function automatic logic [167:0] makeRec(input logic [31:0] pc, input logic h);
      return {h, pc ^ 32'hA5A5_A5A5, pc + 32'h100, pc[3],
              ~pc, pc[6:2], pc[2], instFor(pc, h), pc};
   endfunction

   // Compare one observed value against its expected value and report.
   task automatic checkOutput(input string tag, input logic [167:0] obs,
                              input logic [167:0] expv);
      numChecks++;
      if (obs === expv) begin
         numPass++;
      end else begin
         $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of inputs, then wait until just after the next edge.
   task automatic applyStimulus(input logic c, input logic [31:0] pc,
                                input logic h, input logic rdy);
      commit         = c;
      commit_pc      = pc;
      commit_inst    = instFor(pc, h);
      commit_halt    = h;
      commit_reg_we  = pc[2];
      commit_reg_wa  = pc[6:2];
      commit_reg_wd  = ~pc;
      commit_dmem_we = pc[3];
      commit_dmem_wa = pc + 32'h100;
      commit_dmem_wd = pc ^ 32'hA5A5_A5A5;
      out_ready      = rdy;
      @(posedge clk);
      #1;
   endtask

   // One reset cycle with a commit present that must be ignored.
   task automatic resetDut();
      rst = 1'b1;
      applyStimulus(1'b1, 32'hDEAD_BEE0, 1'b0, 1'b0);
      rst = 1'b0;
   endtask

   logic [31:0]  pcList [16];
   logic [167:0] scoreQ [$];
   logic [167:0] expHead;
   logic         c6;
   logic         rdy6;
   logic [31:0]  pc6;
   int           sent;
   int           recvd;

   initial begin
      rst = 1'b1;
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);

      // ---------------- reset state ----------------
      resetDut();
      checkOutput("rst_occ",      occupancy,  0);
      checkOutput("rst_valid",    out_valid,  0);
      checkOutput("rst_cnt",      commit_cnt, 0);
      checkOutput("rst_rec",      out_rec,    0);
      checkOutput("rst_stall",    stall_req,  0);
      checkOutput("rst_overflow", overflow,   0);
      checkOutput("rst_halted",   halted,     0);

      // ---------------- test 1: pass-through ----------------
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 32'h1C00_0000 + 32'(i * 4), 1'b0, 1'b1);
         checkOutput("t1_valid", out_valid, 1);
         checkOutput("t1_rec", out_rec, makeRec(32'h1C00_0000 + 32'(i * 4), 1'b0));
      end
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t1_cnt",   commit_cnt, 3);
      checkOutput("t1_occ",   occupancy,  0);
      checkOutput("t1_valid0", out_valid, 0);

      // ---------------- test 2: fill and overflow ----------------
      resetDut();
      for (int i = 0; i < 13; i++) begin
         applyStimulus(1'b1, 32'h0000_1000 + 32'(i * 4), 1'b0, 1'b0);
      end
      checkOutput("t2_occ13",   occupancy, 13);
      checkOutput("t2_stall13", stall_req, 0);
      applyStimulus(1'b1, 32'h0000_1000 + 32'(13 * 4), 1'b0, 1'b0);
      checkOutput("t2_occ14",   occupancy, 14);
      checkOutput("t2_stall14", stall_req, 1);
      for (int i = 14; i < 16; i++) begin
         applyStimulus(1'b1, 32'h0000_1000 + 32'(i * 4), 1'b0, 1'b0);
      end
      checkOutput("t2_occ16", occupancy, 16);
      checkOutput("t2_ovf16", overflow,  0);
      applyStimulus(1'b1, 32'h0000_2000, 1'b0, 1'b0);
      checkOutput("t2_ovf",   overflow,   1);
      checkOutput("t2_occ",   occupancy,  16);
      checkOutput("t2_cnt",   commit_cnt, 16);
      checkOutput("t2_head",  out_rec,    makeRec(32'h0000_1000, 1'b0));

      // ---------------- test 3: push+pop while full ----------------
      resetDut();
      for (int i = 0; i < 16; i++) begin
         pcList[i] = 32'h0000_3000 + 32'(i * 4);
         applyStimulus(1'b1, pcList[i], 1'b0, 1'b0);
      end
      checkOutput("t3_head", out_rec, makeRec(pcList[0], 1'b0));
      applyStimulus(1'b1, 32'h0000_3F00, 1'b0, 1'b1);
      checkOutput("t3_occ", occupancy, 16);
      checkOutput("t3_ovf", overflow,  0);
      checkOutput("t3_cnt", commit_cnt, 17);
      for (int i = 1; i < 16; i++) begin
         checkOutput("t3_order", out_rec, makeRec(pcList[i], 1'b0));
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      end
      checkOutput("t3_last", out_rec, makeRec(32'h0000_3F00, 1'b0));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t3_empty", occupancy, 0);

      // ---------------- test 4: halt sequence ----------------
      resetDut();
      applyStimulus(1'b1, 32'h0000_4000, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h0000_4004, 1'b0, 1'b0);
      checkOutput("t4_stall_run", stall_req, 0);
      applyStimulus(1'b1, 32'h0000_4008, 1'b1, 1'b0);
      applyStimulus(1'b1, 32'h0000_400C, 1'b0, 1'b0);
      checkOutput("t4_occ",    occupancy, 3);
      checkOutput("t4_stall",  stall_req, 1);
      checkOutput("t4_halted", halted,    0);
      checkOutput("t4_cnt",    commit_cnt, 3);
      checkOutput("t4_rec0", out_rec, makeRec(32'h0000_4000, 1'b0));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t4_rec1", out_rec, makeRec(32'h0000_4004, 1'b0));
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t4_rec2", out_rec, makeRec(32'h0000_4008, 1'b1));
      checkOutput("t4_haltbit", out_rec[167], 1);
      checkOutput("t4_halted_early", halted, 0);
      applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      checkOutput("t4_occ0",   occupancy, 0);
      checkOutput("t4_halted1", halted,   1);
      applyStimulus(1'b1, 32'h0000_4010, 1'b0, 1'b1);
      checkOutput("t4_ignored_occ", occupancy,  0);
      checkOutput("t4_ignored_cnt", commit_cnt, 3);
      checkOutput("t4_halt_stall",  stall_req,  1);

      // ---------------- test 5: reset mid-stream ----------------
      resetDut();
      for (int i = 0; i < 17; i++) begin
         applyStimulus(1'b1, 32'h0000_5000 + 32'(i * 4), 1'b0, 1'b0);
      end
      for (int i = 0; i < 11; i++) begin
         applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
      end
      checkOutput("t5_occ5", occupancy, 5);
      checkOutput("t5_ovf1", overflow,  1);
      resetDut();
      checkOutput("t5_occ",   occupancy,  0);
      checkOutput("t5_valid", out_valid,  0);
      checkOutput("t5_ovf",   overflow,   0);
      checkOutput("t5_cnt",   commit_cnt, 0);
      checkOutput("t5_stall", stall_req,  0);
      applyStimulus(1'b1, 32'h0000_5500, 1'b0, 1'b0);
      checkOutput("t5_new_occ", occupancy,  1);
      checkOutput("t5_new_cnt", commit_cnt, 1);
      checkOutput("t5_new_rec", out_rec,    makeRec(32'h0000_5500, 1'b0));

      // ---------------- test 6: 40 records through the wrap ----------------
      resetDut();
      sent  = 0;
      recvd = 0;
      for (int cyc = 0; cyc < 2000 && recvd < 40; cyc++) begin
         c6   = (sent < 40) && !stall_req;
         rdy6 = ($urandom_range(0, 2) != 0);
         pc6  = 32'h2000_0000 + 32'(sent * 4);
         if (out_valid && rdy6) begin
            expHead = (scoreQ.size() > 0) ? scoreQ[0] : '0;
            if (scoreQ.size() > 0) begin
               void'(scoreQ.pop_front());
            end
            checkOutput("t6_order", out_rec, expHead);
            recvd++;
         end
         if (c6) begin
            scoreQ.push_back(makeRec(pc6, 1'b0));
            sent++;
         end
         applyStimulus(c6, pc6, 1'b0, rdy6);
      end
      checkOutput("t6_received", recvd,      40);
      checkOutput("t6_cnt",      commit_cnt, 40);
      checkOutput("t6_ovf",      overflow,   0);
      checkOutput("t6_occ",      occupancy,  0);

      $display("[TB] %0d/%0d checks passed", numPass, numChecks);
      $finish;
   end

endmodule
